// File: rtl/systolic_feeder.sv
// systolic_feeder: loads an im2col/weight matrix pair from word memory and streams it row-by-row to a systolic array
// Ports:
//   clk, rst_systolic  rising-edge clock, asynchronous active-low reset
//   start              one-cycle request, accepted only in IDLE
//   rd_en, addr_rd     read strobe and word address (address is 0 when no read)
//   data_rd            read data, valid one cycle after the read is presented
//   X, W               im2col row beat (M words) and weight row beat (K words), element j at word j
//   valid              X/W carry a beat
//   busy, done         operation in progress; one-cycle pulse after the last beat
module systolic_feeder #(
    parameter int M = 3,
    parameter int N = 4,
    parameter int K = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h00002000,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h00001000
) (
    input  logic                    clk,
    input  logic                    rst_systolic,
    input  logic                    start,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    input  logic [DATA_WIDTH-1:0]   data_rd,
    output logic [DATA_WIDTH*M-1:0] X,
    output logic [DATA_WIDTH*K-1:0] W,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);
    localparam int L  = M + K;
    localparam int RI = $clog2(N + 1);
    localparam int CW = $clog2(L);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} state_t;

    state_t                  state_q, state_d;
    logic                    rd_en_q, rd_en_d, v_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, iss_addr;
    logic [DATA_WIDTH*M-1:0] x_q, x_d;
    logic [DATA_WIDTH*K-1:0] w_q, w_d;
    logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [RI-1:0]           ri_q, ri_d, rc_q, rc_d, r_q, r_d;
    logic [CW-1:0]           ci_q, ci_d, cc_q, cc_d;
    logic                    issue, cap_en;
    // one row per reduction step: X words in the low M slots, W words above them
    logic [L*DATA_WIDTH-1:0] row_q [N];

    assign iss_addr = (ci_q < CW'(M))
        ? IM2COL_BASE + ADDR_WIDTH'(ri_q) * ADDR_WIDTH'(M) + ADDR_WIDTH'(ci_q)
        : WEIGHT_BASE + ADDR_WIDTH'(ri_q) * ADDR_WIDTH'(K) + ADDR_WIDTH'(ci_q) - ADDR_WIDTH'(M);

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        addr_d  = '0;
        x_d     = '0;
        w_d     = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ri_d    = ri_q;
        ci_d    = ci_q;
        rc_d    = rc_q;
        cc_d    = cc_q;
        r_d     = r_q;
        issue   = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    issue   = 1'b1;
                end
            end
            LOAD: begin
                issue  = ri_q < RI'(N);
                // v_q marks that data_rd carries the word of the read issued two edges ago
                cap_en = v_q;
                if (v_q) begin
                    rc_d = (cc_q == CW'(L - 1)) ? rc_q + 1'b1 : rc_q;
                    cc_d = (cc_q == CW'(L - 1)) ? '0 : cc_q + 1'b1;
                    if (rc_q == RI'(N - 1) && cc_q == CW'(L - 1))
                        state_d = STREAM;
                end
            end
            STREAM: begin
                if (r_q < RI'(N)) begin
                    x_d     = row_q[r_q[RW-1:0]][M*DATA_WIDTH-1:0];
                    w_d     = row_q[r_q[RW-1:0]][L*DATA_WIDTH-1:M*DATA_WIDTH];
                    valid_d = 1'b1;
                    r_d     = r_q + 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                // counters return to zero so a start on the next IDLE cycle issues read 0
                state_d = IDLE;
                ri_d    = '0;
                ci_d    = '0;
                rc_d    = '0;
                cc_d    = '0;
                r_d     = '0;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            rd_en_d = 1'b1;
            addr_d  = iss_addr;
            ri_d    = (ci_q == CW'(L - 1)) ? ri_q + 1'b1 : ri_q;
            ci_d    = (ci_q == CW'(L - 1)) ? '0 : ci_q + 1'b1;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_systolic) begin
        if (!rst_systolic) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            v_q     <= 1'b0;
            addr_q  <= '0;
            x_q     <= '0;
            w_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ri_q    <= '0;
            ci_q    <= '0;
            rc_q    <= '0;
            cc_q    <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            v_q     <= rd_en_q;
            addr_q  <= addr_d;
            x_q     <= x_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ri_q    <= ri_d;
            ci_q    <= ci_d;
            rc_q    <= rc_d;
            cc_q    <= cc_d;
            r_q     <= r_d;
        end
    end

    // buffer is never visible before it is reloaded, so it carries no reset
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int c = 0; c < L; c++)
                if (cc_q == CW'(c))
                    row_q[rc_q[RW-1:0]][c*DATA_WIDTH +: DATA_WIDTH] <= data_rd;
        end
    end

    assign rd_en   = rd_en_q;
    assign addr_rd = addr_q;
    assign X       = x_q;
    assign W       = w_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed self-checking bench for systolic_feeder with a registered word memory model
module tb_systolic_feeder;
    localparam int M = 3, N = 4, K = 2, DW = 32, AW = 32, T = N * (M + K);

    logic          clk = 1'b0, rst_systolic = 1'b0, start = 1'b0;
    logic          rd_en, valid, busy, done;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] data_rd = '0;
    logic [DW*M-1:0] X;
    logic [DW*K-1:0] W;
    int n_chk = 0, n_fail = 0;
    int xm [N*M];
    int wm [N*K];
    logic [AW-1:0] first_addrs [6] = '{32'h2000, 32'h2001, 32'h2002, 32'h1000, 32'h1001, 32'h2003};

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk(clk), .rst_systolic(rst_systolic), .start(start), .rd_en(rd_en), .addr_rd(addr_rd),
        .data_rd(data_rd), .X(X), .W(W), .valid(valid), .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a >= 32'h2000 && a < 32'h2000 + N*M) return DW'(xm[int'(a) - 'h2000]);
        if (a >= 32'h1000 && a < 32'h1000 + N*K) return DW'(wm[int'(a) - 'h1000]);
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) data_rd <= rd_en ? mem(addr_rd) : '0;

    function automatic logic [AW-1:0] exp_addr(input int e);
        int i, j;
        i = e / (M + K);
        j = e % (M + K);
        return (j < M) ? AW'(32'h2000 + i*M + j) : AW'(32'h1000 + i*K + j - M);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rd_en"}, 128'(rd_en), 0);
        chk({tag, " addr"}, 128'(addr_rd), 0);
        chk({tag, " X"}, 128'(X), 0);
        chk({tag, " W"}, 128'(W), 0);
        chk({tag, " valid"}, 128'(valid), 0);
        chk({tag, " busy"}, 128'(busy), 0);
        chk({tag, " done"}, 128'(done), 0);
    endtask

    // start sampled at edge 0, outputs checked after every edge 0..T+N+3
    task automatic run(input bit lit, input bit extra);
        logic [DW*M-1:0] xe;
        logic [DW*K-1:0] we;
        int r;
        bit v;
        for (int e = 0; e <= T + N + 3; e++) begin
            start = (e == 0) || (extra && (e == 5 || e == 24));
            tick;
            start = 1'b0;
            v = (e >= T + 2) && (e <= T + N + 1);
            r = e - T - 2;
            xe = '0;
            we = '0;
            if (v) begin
                for (int j = 0; j < M; j++) xe[j*DW +: DW] = DW'(xm[r*M + j]);
                for (int j = 0; j < K; j++) we[j*DW +: DW] = DW'(wm[r*K + j]);
            end
            chk($sformatf("rd_en@%0d", e), 128'(rd_en), 128'(e < T));
            chk($sformatf("addr@%0d", e), 128'(addr_rd), (e < T) ? 128'(exp_addr(e)) : 0);
            chk($sformatf("valid@%0d", e), 128'(valid), 128'(v));
            chk($sformatf("X@%0d", e), 128'(X), 128'(xe));
            chk($sformatf("W@%0d", e), 128'(W), 128'(we));
            chk($sformatf("done@%0d", e), 128'(done), 128'(e == T + N + 2));
            chk($sformatf("busy@%0d", e), 128'(busy), 128'(e <= T + N + 2));
            if (lit && e < 6) chk($sformatf("lit_addr@%0d", e), 128'(addr_rd), 128'(first_addrs[e]));
            if (lit && e == 22) begin
                chk("lit_X0", 128'(X), 128'({32'd102, 32'd101, 32'd100}));
                chk("lit_W0", 128'(W), 128'({32'd201, 32'd200}));
            end
            if (lit && e == 25) begin
                chk("lit_X3", 128'(X), 128'({32'd111, 32'd110, 32'd109}));
                chk("lit_W3", 128'(W), 128'({32'd207, 32'd206}));
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int n = 0; n < N*M; n++) xm[n] = 100 + n;
        for (int n = 0; n < N*K; n++) wm[n] = 200 + n;
        #2;
        chk_idle("reset");
        start = 1'b1;
        tick;
        chk_idle("start_in_reset");
        start = 1'b0;
        #3;
        rst_systolic = 1'b1;
        run(1'b1, 1'b0);
        run(1'b0, 1'b1);
        for (int n = 0; n < N*M; n++) xm[n] += 1000;
        for (int n = 0; n < N*K; n++) wm[n] += 1000;
        run(1'b0, 1'b0);

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        chk("midload rd_en", 128'(rd_en), 1);
        chk("midload addr", 128'(addr_rd), 128'(exp_addr(10)));
        #2;
        rst_systolic = 1'b0;
        #1;
        chk_idle("load_abort");
        tick;
        tick;
        chk_idle("load_abort_hold");
        rst_systolic = 1'b1;
        run(1'b0, 1'b0);

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (T + 3) tick;
        chk("midstream valid", 128'(valid), 1);
        chk("midstream X1", 128'(X), 128'({DW'(xm[5]), DW'(xm[4]), DW'(xm[3])}));
        chk("midstream W1", 128'(W), 128'({DW'(wm[3]), DW'(wm[2])}));
        #2;
        rst_systolic = 1'b0;
        #1;
        chk_idle("stream_abort");
        tick;
        rst_systolic = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            chk($sformatf("stream_abort done@%0d", c), 128'(done), 0);
            chk($sformatf("stream_abort busy@%0d", c), 128'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
